// File: rtl/hex_io_pkg.sv
// Shared types and constants for the hex keypad reader.
//
// Contents:
//   key_state_e  - press/release tracking FSM states
//   scan_class_e - classification of one complete keypad scan
//   KEY_COLS     - number of keypad columns (and rows) scanned
package hex_io_pkg;

    localparam int KEY_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_e;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_class_e;

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 matrix keypad.
//
// Drives one column low at a time for SCAN_DIV clocks and synchronizes the
// row lines.  The rows are sampled on the last cycle of each column period,
// which gives them time to settle.  The closures seen over the four columns
// are merged into one classification for the whole scan.
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   rows_i       - raw active-low row lines (asynchronous to clk_i)
//   cols_o       - active-low one-hot column drive
//   scan_done_o  - one-cycle pulse on the clock after column 3 is sampled
//   scan_class_o - NONE / SINGLE / MULTI for the scan just completed
//   scan_code_o  - {row, col} of the closed key, meaningful for SINGLE
module keypad_scanner
    import hex_io_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [KEY_COLS-1:0] rows_i,
    output logic [KEY_COLS-1:0] cols_o,
    output logic                scan_done_o,
    output scan_class_e         scan_class_o,
    output logic [3:0]          scan_code_o
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [KEY_COLS-1:0] rows_meta_q;
    logic [KEY_COLS-1:0] rows_sync_q;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          col_q, col_d;
    logic [KEY_COLS-1:0] cols_q, cols_d;
    scan_class_e         acc_class_q, acc_class_d;
    logic [3:0]          acc_code_q, acc_code_d;
    logic                done_q, done_d;

    logic                col_last;
    logic [KEY_COLS-1:0] closed;
    logic [2:0]          n_closed;
    scan_class_e         base_class;

    function automatic logic [2:0] count_ones(input logic [KEY_COLS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < KEY_COLS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    function automatic logic [1:0] low_index(input logic [KEY_COLS-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = KEY_COLS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    assign col_last = (div_q == DIV_LAST);
    assign closed   = ~rows_sync_q;
    assign n_closed = count_ones(closed);

    always_comb begin
        div_d       = col_last ? '0 : div_q + DIV_W'(1);
        col_d       = col_q;
        cols_d      = cols_q;
        acc_class_d = acc_class_q;
        acc_code_d  = acc_code_q;
        done_d      = 1'b0;
        // Column 0 starts a fresh scan; later columns build on what was seen.
        base_class  = (col_q == 2'd0) ? SCAN_NONE : acc_class_q;

        if (col_last) begin
            col_d  = col_q + 2'd1;
            cols_d = ~(KEY_COLS'(1) << col_d);
            if (n_closed >= 3'd2) begin
                acc_class_d = SCAN_MULTI;
            end else if (n_closed == 3'd1) begin
                if (base_class == SCAN_NONE) begin
                    acc_class_d = SCAN_SINGLE;
                    acc_code_d  = {low_index(closed), col_q};
                end else begin
                    acc_class_d = SCAN_MULTI;
                end
            end else begin
                acc_class_d = base_class;
            end
            done_d = (col_q == 2'd3);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_meta_q <= '1;
            rows_sync_q <= '1;
            div_q       <= '0;
            col_q       <= 2'd0;
            cols_q      <= 4'b1110;
            acc_class_q <= SCAN_NONE;
            acc_code_q  <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            rows_meta_q <= rows_i;
            rows_sync_q <= rows_meta_q;
            div_q       <= div_d;
            col_q       <= col_d;
            cols_q      <= cols_d;
            acc_class_q <= acc_class_d;
            acc_code_q  <= acc_code_d;
            done_q      <= done_d;
        end
    end

    // The accumulator holds the final result for the whole pulse: it is not
    // rewritten until the next column-0 sample, SCAN_DIV clocks later.
    assign cols_o       = cols_q;
    assign scan_done_o  = done_q;
    assign scan_class_o = acc_class_q;
    assign scan_code_o  = acc_code_q;

endmodule

// File: rtl/hex_keypad_reader.sv
// Hex keypad reader: scans a 4x4 keypad, debounces presses and releases,
// and keeps the last eight accepted digits for an 8-digit hex display.
//
// A press is accepted after DEBOUNCE consecutive scans that each show the same
// single key.  Once accepted, the key must read as released for DEBOUNCE
// consecutive scans before another press can be accepted.  Holding a key or
// adding keys while held (rollover) never produces a second press.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   rows      - keypad rows, active-low, asynchronous to clk
//   cols      - keypad column drive, active-low one-hot
//   clear     - synchronous clear of data
//   key_code  - hex value of the last accepted key
//   key_valid - one-cycle pulse per accepted press
//   data      - last 8 accepted digits, newest in data[3:0]
module hex_keypad_reader
    import hex_io_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_COLS-1:0] rows,
    output logic [KEY_COLS-1:0] cols,
    input  logic                clear,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic [31:0]         data
);

    localparam int               CNT_W   = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic        scan_done;
    scan_class_e scan_class;
    logic [3:0]  scan_code;

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic [31:0]      data_q, data_d;
    logic             accept;
    logic [3:0]       accept_code;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rows_i       (rows),
        .cols_o       (cols),
        .scan_done_o  (scan_done),
        .scan_class_o (scan_class),
        .scan_code_o  (scan_code)
    );

    assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        accept      = 1'b0;
        accept_code = cand_q;

        if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_class == SCAN_SINGLE) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_ONE;
                        // A single clean scan is enough when DEBOUNCE is 1.
                        if (DEBOUNCE == 1) begin
                            accept      = 1'b1;
                            accept_code = scan_code;
                            state_d     = ST_PRESSED;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_class == SCAN_SINGLE && scan_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            accept  = 1'b1;
                            state_d = ST_PRESSED;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (scan_class == SCAN_NONE) begin
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE == 1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (scan_class == SCAN_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        key_valid_d = accept;
        key_code_d  = accept ? accept_code : key_code_q;
        // clear has priority over a coincident accept for the digit history.
        if (clear) begin
            data_d = 32'd0;
        end else if (accept) begin
            data_d = {data_q[27:0], accept_code};
        end else begin
            data_d = data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            data_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            data_q      <= data_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign data      = data_q;

endmodule

// File: tb/tb_hex_keypad_reader.sv
`timescale 1ns/1ps
module tb_hex_keypad_reader;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 2;
    localparam int SCAN_CLK = 4 * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        clear;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [31:0] data;

    // Pressed keys, bit index = row*4 + col (equal to the key's hex code).
    logic [15:0] keys;

    int n_checks;
    int n_fail;

    hex_keypad_reader #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows      (rows),
        .cols      (cols),
        .clear     (clear),
        .key_code  (key_code),
        .key_valid (key_valid),
        .data      (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    // ---------------- reference model (per-scan behaviour) ----------------
    bit          m_armed;     // released long enough to accept a new press
    int          m_run;       // consecutive identical single-key scans
    logic [3:0]  m_cand;
    int          m_none_run;  // consecutive empty scans while held
    logic [3:0]  m_code;
    logic [31:0] m_data;
    int          m_pend;      // pulses expected in the following scan

    task automatic model_reset();
        m_armed = 1'b1; m_run = 0; m_cand = 4'd0; m_none_run = 0;
        m_code = 4'd0; m_data = 32'd0; m_pend = 0;
    endtask

    task automatic model_scan(input logic [15:0] k, input bit clr);
        int         n;
        logic [3:0] code;
        n = $countones(k);
        code = 4'd0;
        for (int i = 15; i >= 0; i--) if (k[i]) code = 4'(i);
        m_pend = 0;
        if (m_armed) begin
            if (n == 1) begin
                if (m_run > 0 && code == m_cand) m_run++;
                else if (m_run > 0) m_run = 0;
                else begin m_cand = code; m_run = 1; end
                if (m_run >= DB) begin
                    m_pend = 1; m_code = m_cand;
                    m_data = {m_data[27:0], m_cand};
                    m_armed = 1'b0; m_none_run = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_none_run++;
                if (m_none_run >= DB) begin m_armed = 1'b1; m_run = 0; end
            end else begin
                m_none_run = 0;
            end
        end
        if (clr) m_data = 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full scan with a constant key set. Pulses seen during this scan
    // come from the previous scan's decision; clr is raised for the clock
    // edge on which this scan's decision lands.
    task automatic run_scan(input logic [15:0] k, input bit clr, output int pulses);
        keys = k;
        pulses = 0;
        for (int i = 0; i < SCAN_CLK; i++) begin
            @(posedge clk); #1;
            if (i == 0) clear = 1'b0;
            if (key_valid) pulses++;
        end
        chk("model_pulses", 32'(pulses), 32'(m_pend));
        chk("model_key_code", {28'd0, key_code}, {28'd0, m_code});
        chk("model_data", data, m_data);
        model_scan(k, clr);
        if (clr) clear = 1'b1;
    endtask

    typedef struct {
        logic [15:0] keys;
        int          exp_pulses;
        logic [3:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int total;
        logic [15:0] k;

        n_checks = 0; n_fail = 0;
        keys = 16'd0; clear = 1'b0; rst_n = 1'b0;
        model_reset();

        // key 9 held 5 scans, then release; bounce of key 5; keys 0+7 together
        tbl[0]  = '{16'h0200, 0, 4'h0, 32'h0};
        tbl[1]  = '{16'h0200, 0, 4'h0, 32'h0};
        tbl[2]  = '{16'h0200, 1, 4'h9, 32'h9};
        tbl[3]  = '{16'h0200, 0, 4'h9, 32'h9};
        tbl[4]  = '{16'h0200, 0, 4'h9, 32'h9};
        tbl[5]  = '{16'h0000, 0, 4'h9, 32'h9};
        tbl[6]  = '{16'h0000, 0, 4'h9, 32'h9};
        tbl[7]  = '{16'h0000, 0, 4'h9, 32'h9};
        tbl[8]  = '{16'h0020, 0, 4'h9, 32'h9};
        tbl[9]  = '{16'h0000, 0, 4'h9, 32'h9};
        tbl[10] = '{16'h0000, 0, 4'h9, 32'h9};
        tbl[11] = '{16'h0081, 0, 4'h9, 32'h9};
        tbl[12] = '{16'h0081, 0, 4'h9, 32'h9};
        tbl[13] = '{16'h0001, 0, 4'h9, 32'h9};
        tbl[14] = '{16'h0001, 0, 4'h9, 32'h9};
        tbl[15] = '{16'h0001, 1, 4'h0, 32'h90};
        tbl[16] = '{16'h0000, 0, 4'h0, 32'h90};
        tbl[17] = '{16'h0000, 0, 4'h0, 32'h90};

        #12;
        chk("reset_cols", {28'd0, cols}, 32'hE);
        chk("reset_key_valid", {31'd0, key_valid}, 32'd0);
        chk("reset_key_code", {28'd0, key_code}, 32'd0);
        chk("reset_data", data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_scan(tbl[i].keys, 1'b0, p);
            chk($sformatf("tbl%0d_pulses", i), 32'(p), 32'(tbl[i].exp_pulses));
            chk($sformatf("tbl%0d_key_code", i), {28'd0, key_code}, {28'd0, tbl[i].exp_code});
            chk($sformatf("tbl%0d_data", i), data, tbl[i].exp_data);
        end

        // Digits 1..9, each held 3 scans and released 3 scans.
        total = 0;
        for (int d = 1; d <= 9; d++) begin
            k = 16'd1 << d;
            for (int s = 0; s < 3; s++) begin run_scan(k, 1'b0, p); total += p; end
            for (int s = 0; s < 3; s++) begin run_scan(16'd0, 1'b0, p); total += p; end
        end
        chk("seq_pulses", 32'(total), 32'd9);
        chk("seq_data", data, 32'h2345_6789);

        // clear coincident with the accept of key A
        run_scan(16'h0400, 1'b0, p);
        run_scan(16'h0400, 1'b1, p);
        run_scan(16'h0400, 1'b0, p);
        chk("clr_pulses", 32'(p), 32'd1);
        chk("clr_key_code", {28'd0, key_code}, 32'hA);
        chk("clr_data", data, 32'd0);
        run_scan(16'h0000, 1'b0, p);
        run_scan(16'h0000, 1'b0, p);

        // randomized key activity
        for (int it = 0; it < 40; it++) begin
            int kind, hold, i1, i2;
            bit clr;
            kind = $urandom_range(0, 3);
            i1 = $urandom_range(0, 15);
            i2 = (i1 + 1 + $urandom_range(0, 14)) % 16;
            case (kind)
                0:       k = 16'd0;
                3:       k = (16'd1 << i1) | (16'd1 << i2);
                default: k = 16'd1 << i1;
            endcase
            hold = $urandom_range(1, 3);
            for (int s = 0; s < hold; s++) begin
                clr = ($urandom_range(0, 7) == 0);
                run_scan(k, clr, p);
            end
        end
        run_scan(16'd0, 1'b0, p);
        run_scan(16'd0, 1'b0, p);
        run_scan(16'd0, 1'b0, p);

        // reset while key 3 is held in the pressed state
        run_scan(16'h0008, 1'b0, p);
        run_scan(16'h0008, 1'b0, p);
        run_scan(16'h0008, 1'b0, p);
        chk("pre_rst_key_code", {28'd0, key_code}, 32'h3);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_cols", {28'd0, cols}, 32'hE);
        chk("midrst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("midrst_key_code", {28'd0, key_code}, 32'd0);
        chk("midrst_data", data, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total = 0;
        run_scan(16'h0008, 1'b0, p); total += p;
        run_scan(16'h0008, 1'b0, p); total += p;
        run_scan(16'h0008, 1'b0, p); total += p;
        chk("postrst_pulse_at_scan2", 32'(p), 32'd1);
        run_scan(16'h0008, 1'b0, p); total += p;
        chk("postrst_total_pulses", 32'(total), 32'd1);
        chk("postrst_key_code", {28'd0, key_code}, 32'h3);
        chk("postrst_data", data, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
